// File: rtl/core_pkg.sv
// Shared core types: opcode constants, forwarding-select encodings and the hazard scoreboard entry.
// Pure declarations, so there is no latency or backpressure here.
package core_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_R      = 7'b0110011,
    OPC_I      = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_LUI    = 7'b0110111
  } opcode_e;

  localparam int FWD_RF = 0;

  // Wide enough for the largest legal load latency (NUM_FWD_STAGES-1 <= 6).
  localparam int SB_CNT_W = 3;

  typedef struct packed {
    logic                vld;
    logic [4:0]          rd;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

  function automatic logic [SB_CNT_W-1:0] cnt_dec(input logic [SB_CNT_W-1:0] c);
    return (c == '0) ? '0 : c - SB_CNT_W'(1);
  endfunction

endpackage

// File: rtl/hazard_operand_match.sv
// Priority match of one source operand against the scoreboard, youngest entry first.
// Combinational, zero latency; raises hazard when the matched result is not yet forwardable.
import core_pkg::*;

module hazard_operand_match #(
  parameter int NUM_ENT = 2,
  parameter int FWD_W   = 2
) (
  input  sb_entry_t [NUM_ENT-1:0] sb,
  input  logic [4:0]              rs,
  input  logic                    used,
  output logic [FWD_W-1:0]        sel,
  output logic                    hazard
);

  // Scan oldest to youngest so the youngest candidate overwrites the result.
  always_comb begin
    sel    = FWD_W'(FWD_RF);
    hazard = 1'b0;
    for (int i = NUM_ENT - 1; i >= 0; i--) begin
      if (used && (rs != 5'd0) && sb[i].vld && (sb[i].rd == rs)) begin
        if (sb[i].cnt == '0) begin
          sel    = FWD_W'(i + 1);
          hazard = 1'b0;
        end else begin
          sel    = FWD_W'(FWD_RF);
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding select, load-use stall, redirect flush and freeze control beside decode; outputs are combinational (0 cycles).
// mem_busy drops advance, freezing the scoreboard and counters until memory is ready again.
import core_pkg::*;

module pipe_hazard_ctrl #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT       = 1,
  parameter int FWD_W          = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_wr,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             advance,
  output logic             id_stall,
  output logic             flush,
  output logic [FWD_W-1:0] fwd_a_sel,
  output logic [FWD_W-1:0] fwd_b_sel,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
);

  sb_entry_t [NUM_FWD_STAGES-1:0] sb;
  logic                           hazard_a;
  logic                           hazard_b;
  logic                           issue;

  hazard_operand_match #(.NUM_ENT(NUM_FWD_STAGES), .FWD_W(FWD_W)) u_match_a (
    .sb     (sb),
    .rs     (id_rs1),
    .used   (id_rs1_used),
    .sel    (fwd_a_sel),
    .hazard (hazard_a)
  );

  hazard_operand_match #(.NUM_ENT(NUM_FWD_STAGES), .FWD_W(FWD_W)) u_match_b (
    .sb     (sb),
    .rs     (id_rs2),
    .used   (id_rs2_used),
    .sel    (fwd_b_sel),
    .hazard (hazard_b)
  );

  assign advance  = !mem_busy;
  assign flush    = ex_redirect & advance;
  assign id_stall = id_valid & (hazard_a | hazard_b) & !flush;
  // A stalled or flushed decode slot becomes a bubble in EX.
  assign issue    = id_valid & !id_stall & !flush & id_rd_wr & (id_rd != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb           <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else if (advance) begin
      sb[0].vld <= issue;
      sb[0].rd  <= id_rd;
      sb[0].cnt <= id_is_load ? SB_CNT_W'(LOAD_LAT) : '0;
      for (int i = 1; i < NUM_FWD_STAGES; i++) begin
        sb[i].vld <= sb[i-1].vld;
        sb[i].rd  <= sb[i-1].rd;
        sb[i].cnt <= cnt_dec(sb[i-1].cnt);
      end
      if (id_stall) stall_cycles <= stall_cycles + 32'd1;
      if (flush)    flush_count  <= flush_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks of pipe_hazard_ctrl in three configurations sharing one stimulus stream.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_rd_wr, id_is_load;
  logic       ex_redirect, mem_busy;

  // a: N=2 L=1, b: N=4 L=2, c: N=2 L=0
  logic        a_adv, a_stall, a_flush;
  logic [1:0]  a_fa, a_fb;
  logic [31:0] a_sc, a_fc;
  logic        b_adv, b_stall, b_flush;
  logic [2:0]  b_fa, b_fb;
  logic [31:0] b_sc, b_fc;
  logic        c_adv, c_stall, c_flush;
  logic [1:0]  c_fa, c_fb;
  logic [31:0] c_sc, c_fc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.NUM_FWD_STAGES(2), .LOAD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .advance(a_adv), .id_stall(a_stall), .flush(a_flush),
    .fwd_a_sel(a_fa), .fwd_b_sel(a_fb), .stall_cycles(a_sc), .flush_count(a_fc)
  );

  pipe_hazard_ctrl #(.NUM_FWD_STAGES(4), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .advance(b_adv), .id_stall(b_stall), .flush(b_flush),
    .fwd_a_sel(b_fa), .fwd_b_sel(b_fb), .stall_cycles(b_sc), .flush_count(b_fc)
  );

  pipe_hazard_ctrl #(.NUM_FWD_STAGES(2), .LOAD_LAT(0)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .advance(c_adv), .id_stall(c_stall), .flush(c_flush),
    .fwd_a_sel(c_fa), .fwd_b_sel(c_fb), .stall_cycles(c_sc), .flush_count(c_fc)
  );

  typedef enum int {
    O_ADV, O_STALL, O_FLUSH, O_FA, O_FB, O_SC, O_FC,
    O_B_STALL, O_B_FA, O_B_SC, O_C_STALL, O_C_FA
  } obs_e;

  typedef struct {
    string       tag;
    obs_e        id;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errs    = 0;

  function automatic logic [31:0] observe(input obs_e id);
    case (id)
      O_ADV:     return {31'd0, a_adv};
      O_STALL:   return {31'd0, a_stall};
      O_FLUSH:   return {31'd0, a_flush};
      O_FA:      return {30'd0, a_fa};
      O_FB:      return {30'd0, a_fb};
      O_SC:      return a_sc;
      O_FC:      return a_fc;
      O_B_STALL: return {31'd0, b_stall};
      O_B_FA:    return {29'd0, b_fa};
      O_B_SC:    return b_sc;
      O_C_STALL: return {31'd0, c_stall};
      O_C_FA:    return {30'd0, c_fa};
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_out(input string tag, input obs_e id, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.id  = id;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = observe(e.id);
      vectors++;
      assert (o === e.val) else begin
        errs++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
      end
    end
  endtask

  // Inputs change just after negedge; outputs are checked 2 time units later, well clear of posedge.
  task automatic tick();
    #2;
    drain();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_rd_wr = 0; id_is_load = 0; ex_redirect = 0; mem_busy = 0;
  endtask

  task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
    id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_rd_wr = wr; id_is_load = ld;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    // Reset state
    expect_out("rst_advance", O_ADV, 1);
    expect_out("rst_stall", O_STALL, 0);
    expect_out("rst_flush", O_FLUSH, 0);
    expect_out("rst_fwd_a", O_FA, 0);
    expect_out("rst_fwd_b", O_FB, 0);
    expect_out("rst_stall_cycles", O_SC, 0);
    expect_out("rst_flush_count", O_FC, 0);
    tick();
    rst = 1'b0;
    tick();

    // addi x5 then add x6,x5,x5, then a later reader of x5
    dec(5'd1, 1, 5'd0, 0, 5'd5, 1, 0);
    expect_out("addi_fwd_a", O_FA, 0);
    tick();
    dec(5'd5, 1, 5'd5, 1, 5'd6, 1, 0);
    expect_out("add_fwd_a", O_FA, 1);
    expect_out("add_fwd_b", O_FB, 1);
    expect_out("add_stall", O_STALL, 0);
    tick();
    dec(5'd5, 1, 5'd0, 0, 5'd9, 1, 0);
    expect_out("sub_fwd_a_wb", O_FA, 2);
    tick();
    idle(); tick(); tick();

    // lw x7 then add x8,x7,x0
    dec(5'd2, 1, 5'd0, 0, 5'd7, 1, 1);
    tick();
    dec(5'd7, 1, 5'd0, 1, 5'd8, 1, 0);
    expect_out("lu_stall", O_STALL, 1);
    expect_out("lu_fwd_a_hold", O_FA, 0);
    expect_out("lu_fwd_b_x0", O_FB, 0);
    expect_out("lu_sc_before", O_SC, 0);
    expect_out("lat0_no_stall", O_C_STALL, 0);
    expect_out("lat0_fwd_a", O_C_FA, 1);
    tick();
    expect_out("lu_stall_done", O_STALL, 0);
    expect_out("lu_fwd_a_wb", O_FA, 2);
    expect_out("lu_sc_after", O_SC, 1);
    tick();
    idle(); tick(); tick();

    // redirect together with a load-use hazard
    dec(5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
    tick();
    dec(5'd10, 1, 5'd0, 0, 5'd11, 1, 0);
    ex_redirect = 1;
    expect_out("fl_flush", O_FLUSH, 1);
    expect_out("fl_stall", O_STALL, 0);
    expect_out("fl_fc_before", O_FC, 0);
    expect_out("fl_sc_hold", O_SC, 1);
    tick();
    ex_redirect = 0;
    dec(5'd11, 1, 5'd10, 1, 5'd0, 0, 0);
    expect_out("fl_flush_clear", O_FLUSH, 0);
    expect_out("fl_bubble_fwd_a", O_FA, 0);
    expect_out("fl_ex_kept_fwd_b", O_FB, 2);
    expect_out("fl_fc_after", O_FC, 1);
    tick();
    idle(); tick(); tick();

    // mem_busy for 3 cycles during a load-use stall
    dec(5'd0, 0, 5'd0, 0, 5'd12, 1, 1);
    tick();
    dec(5'd12, 1, 5'd0, 0, 5'd13, 1, 0);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      expect_out("mb_advance", O_ADV, 0);
      expect_out("mb_stall", O_STALL, 1);
      expect_out("mb_fwd_a", O_FA, 0);
      expect_out("mb_sc_frozen", O_SC, 1);
      tick();
    end
    mem_busy = 0;
    expect_out("mb_resume_adv", O_ADV, 1);
    expect_out("mb_resume_stall", O_STALL, 1);
    expect_out("mb_resume_sc", O_SC, 1);
    tick();
    expect_out("mb_after_stall", O_STALL, 0);
    expect_out("mb_after_fwd_a", O_FA, 2);
    expect_out("mb_after_sc", O_SC, 2);
    tick();
    idle(); tick(); tick();

    // two writers of x3, youngest wins
    dec(5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
    tick();
    dec(5'd0, 0, 5'd0, 0, 5'd3, 1, 0);
    tick();
    dec(5'd3, 1, 5'd3, 1, 5'd0, 0, 0);
    expect_out("dup_fwd_a", O_FA, 1);
    expect_out("dup_fwd_b", O_FB, 1);
    expect_out("dup_stall", O_STALL, 0);
    tick();
    // rd = x0 is never tracked
    dec(5'd0, 0, 5'd0, 0, 5'd0, 1, 0);
    tick();
    dec(5'd0, 1, 5'd0, 0, 5'd0, 0, 0);
    expect_out("x0_fwd_a", O_FA, 0);
    tick();

    // reset mid-stream
    dec(5'd0, 0, 5'd0, 0, 5'd4, 1, 0);
    tick();
    dec(5'd0, 0, 5'd0, 0, 5'd14, 1, 0);
    tick();
    dec(5'd4, 1, 5'd14, 1, 5'd0, 0, 0);
    expect_out("pre_rst_fwd_a", O_FA, 2);
    expect_out("pre_rst_fwd_b", O_FB, 1);
    tick();
    rst = 1'b1;
    expect_out("mid_rst_fwd_a", O_FA, 0);
    expect_out("mid_rst_fwd_b", O_FB, 0);
    expect_out("mid_rst_sc", O_SC, 0);
    expect_out("mid_rst_fc", O_FC, 0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // deeper pipe, LOAD_LAT = 2: two stall cycles then forward from stage 3
    dec(5'd0, 0, 5'd0, 0, 5'd7, 1, 1);
    tick();
    dec(5'd7, 1, 5'd0, 0, 5'd0, 0, 0);
    expect_out("deep_stall_1", O_B_STALL, 1);
    expect_out("deep_fwd_a_1", O_B_FA, 0);
    tick();
    expect_out("deep_stall_2", O_B_STALL, 1);
    expect_out("deep_fwd_a_2", O_B_FA, 0);
    tick();
    expect_out("deep_stall_done", O_B_STALL, 0);
    expect_out("deep_fwd_a", O_B_FA, 3);
    expect_out("deep_sc", O_B_SC, 2);
    tick();
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
